// File: rtl/sync_fifo_sc.sv
// Single-clock first-word-fall-through FIFO with 2^aw words of dw bits, exact and
// near-threshold full/empty flags in combinational and registered form, and a coarse fill level.
module sync_fifo_sc #(
   parameter int unsigned dw = 8,
   parameter int unsigned aw = 4,
   parameter int unsigned n  = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [dw-1:0] din,
   input  logic          we,
   output logic [dw-1:0] dout,
   input  logic          re,
   output logic          full,
   output logic          empty,
   output logic          full_r,
   output logic          empty_r,
   output logic          full_n,
   output logic          empty_n,
   output logic          full_n_r,
   output logic          empty_n_r,
   output logic [1:0]    level
);

   localparam int unsigned Depth = 1 << aw;
   localparam logic [aw:0]   DepthC  = (aw+1)'(Depth);
   localparam logic [aw:0]   NearC   = (aw+1)'(n);
   localparam logic [aw:0]   HiThr   = (aw+1)'(Depth - n);
   localparam logic [aw:0]   CntOne  = (aw+1)'(1);
   localparam logic [aw-1:0] PtrOne  = aw'(1);

   logic [dw-1:0] mem_q [Depth];
   logic [aw-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [aw:0]   cnt_q, cnt_d;
   logic          full_r_q, empty_r_q, full_n_r_q, empty_n_r_q;
   logic          wr, rd, flush;

   assign flush = rst | clr;
   assign wr    = we & ~full;
   assign rd    = re & ~empty;

   assign full    = (cnt_q == DepthC);
   assign empty   = (cnt_q == '0);
   assign full_n  = (cnt_q >= HiThr);
   assign empty_n = (cnt_q <= NearC);
   assign level   = {2{full}} | cnt_q[aw-1:aw-2];
   assign dout    = mem_q[rp_q];

   assign full_r    = full_r_q;
   assign empty_r   = empty_r_q;
   assign full_n_r  = full_n_r_q;
   assign empty_n_r = empty_n_r_q;

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (wr) wp_d = wp_q + PtrOne;
      if (rd) rp_d = rp_q + PtrOne;
      unique case ({wr, rd})
         2'b10:   cnt_d = cnt_q + CntOne;
         2'b01:   cnt_d = cnt_q - CntOne;
         default: cnt_d = cnt_q;
      endcase
   end

   // Registered flags are loaded from next-state count so they track the combinational ones.
   always_ff @(posedge clk) begin
      if (flush) begin
         wp_q        <= '0;
         rp_q        <= '0;
         cnt_q       <= '0;
         full_r_q    <= 1'b0;
         empty_r_q   <= 1'b1;
         full_n_r_q  <= 1'b0;
         empty_n_r_q <= 1'b1;
      end else begin
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         cnt_q       <= cnt_d;
         full_r_q    <= (cnt_d == DepthC);
         empty_r_q   <= (cnt_d == '0);
         full_n_r_q  <= (cnt_d >= HiThr);
         empty_n_r_q <= (cnt_d <= NearC);
      end
   end

   // Storage is never cleared; only the pointers are.
   always_ff @(posedge clk) begin
      if (!flush && wr) mem_q[wp_q] <= din;
   end

endmodule

// File: tb/tb_sync_fifo_sc.sv
// Bench for sync_fifo_sc: directed scenarios plus random traffic, checked against a
// queue-based reference model of the FIFO contents.
module tb_sync_fifo_sc;

   localparam int unsigned Dw    = 8;
   localparam int unsigned Aw    = 4;
   localparam int unsigned N     = 2;
   localparam int unsigned Depth = 1 << Aw;

   logic          clk = 1'b0;
   logic          rst, clr, we, re;
   logic [Dw-1:0] din, dout;
   logic          full, empty, full_r, empty_r, full_n, empty_n, full_n_r, empty_n_r;
   logic [1:0]    level;

   int unsigned   vectors = 0;
   int unsigned   miscompares = 0;
   logic [Dw-1:0] q [$];
   logic [Dw-1:0] saved [$];

   sync_fifo_sc #(.dw(Dw), .aw(Aw), .n(N)) dut (
      .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .dout(dout), .re(re),
      .full(full), .empty(empty), .full_r(full_r), .empty_r(empty_r),
      .full_n(full_n), .empty_n(empty_n), .full_n_r(full_n_r), .empty_n_r(empty_n_r),
      .level(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int unsigned sz;
      sz = q.size();
      chk("empty",     32'(empty),     32'(sz == 0));
      chk("empty_r",   32'(empty_r),   32'(sz == 0));
      chk("full",      32'(full),      32'(sz == Depth));
      chk("full_r",    32'(full_r),    32'(sz == Depth));
      chk("full_n",    32'(full_n),    32'(sz >= Depth - N));
      chk("full_n_r",  32'(full_n_r),  32'(sz >= Depth - N));
      chk("empty_n",   32'(empty_n),   32'(sz <= N));
      chk("empty_n_r", 32'(empty_n_r), 32'(sz <= N));
      chk("level",     32'(level),     (sz == Depth) ? 32'd3 : 32'(sz / (Depth / 4)));
      if (sz != 0) chk("dout", 32'(dout), 32'(q[0]));
   endtask

   // One clock: drive inputs, advance the reference model at the edge, check 1 time unit later.
   task automatic step(input logic r, input logic c, input logic w, input logic rd_en,
                       input logic [Dw-1:0] d);
      bit acc_w, acc_r;
      rst = r; clr = c; we = w; re = rd_en; din = d;
      @(posedge clk);
      if (r || c) begin
         q.delete();
      end else begin
         acc_w = w && (q.size() < Depth);
         acc_r = rd_en && (q.size() > 0);
         if (acc_r) void'(q.pop_front());
         if (acc_w) q.push_back(d);
      end
      #1;
      check_all();
   endtask

   initial begin
      logic [Dw-1:0] v;
      logic [Dw-1:0] burst [4];
      burst[0] = 8'hAA; burst[1] = 8'hBB; burst[2] = 8'hCC; burst[3] = 8'hDD;
      rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; din = '0;

      // Reset, then clear
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("rst_level", 32'(level), 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("clr_empty", 32'(empty), 32'd1);

      // Burst write then five reads
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, burst[i]);
      for (int i = 0; i < 4; i++) begin
         chk("burst_dout", 32'(dout), 32'(burst[i]));
         step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("burst_empty", 32'(empty), 32'd1);

      // Fill to full, overflow write, drain
      saved.delete();
      for (int i = 0; i < Depth; i++) begin
         v = 8'($urandom);
         saved.push_back(v);
         step(1'b0, 1'b0, 1'b1, 1'b0, v);
         if (i == Depth - N - 2) chk("fill_full_n_13", 32'(full_n), 32'd0);
         if (i == Depth - N - 1) chk("fill_full_n_14", 32'(full_n), 32'd1);
      end
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_level", 32'(level), 32'd3);
      step(1'b0, 1'b0, 1'b1, 1'b0, ~saved[0]);
      for (int i = 0; i < Depth; i++) begin
         chk("drain_dout", 32'(dout), 32'(saved[i]));
         step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      end

      // Simultaneous write and read at count 3
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h31);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h32);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h33);
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'h34);
      chk("simul_dout", 32'(dout), 32'h32);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("simul_tail_empty", 32'(empty), 32'd1);

      // Wrap-around: two rounds of 10 writes then 10 reads
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'($urandom));
         for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      end

      // Clear with a concurrent write at count 5
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
      chk("clr_mid_empty", 32'(empty), 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
      chk("clr_mid_dout", 32'(dout), 32'h77);

      // Random traffic with occasional reset/clear
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
              ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
